// File: rtl/alu_pkg.sv
// Shared types for the ALU command driver: opcodes, operand-B
// source codes, driver state encoding and the latched command bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_MUL = 4'b0010,
        OP_AND = 4'b0011,
        OP_OR  = 4'b0100,
        OP_XOR = 4'b0101,
        OP_SLL = 4'b0110,
        OP_SRL = 4'b0111
    } alu_op_e;

    localparam logic [1:0] MOVI_REG_B = 2'b00;
    localparam logic [1:0] MOVI_MEM   = 2'b01;
    localparam logic [1:0] MOVI_IMM   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_HOLD
    } drv_state_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  movi;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] mem;
        logic [31:0] imm;
        logic [3:0]  tag;
        logic        wide;
    } alu_cmd_t;

    // Only multiply produces a second (high) result beat.
    function automatic logic is_wide(input logic [3:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_driver_wdog.sv
// Per-phase wait counter: cleared on phase entry, counts while enabled,
// flags the last allowed cycle of the phase.
module alu_wdog #(
    parameter int TIMEOUT = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = enable && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/alu_driver.sv
// Accepts one command, issues it to the ALU, collects one or two
// result beats and holds the result until the consumer acknowledges.
module alu_driver
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VLD,
    output logic        REQ_RDY,
    input  logic [3:0]  REQ_OP,
    input  logic [1:0]  REQ_MOVI,
    input  logic [31:0] REQ_A,
    input  logic [31:0] REQ_B,
    input  logic [31:0] REQ_MEM,
    input  logic [31:0] REQ_IMM,
    input  logic [3:0]  REQ_TAG,
    output logic        ALU_ACT,
    output logic [3:0]  ALU_OP,
    output logic [1:0]  ALU_MOVI,
    output logic [31:0] ALU_REG_A,
    output logic [31:0] ALU_REG_B,
    output logic [31:0] ALU_MEM,
    output logic [31:0] ALU_IMM,
    input  logic [31:0] ALU_DATA,
    input  logic        ALU_RDY,
    input  logic        ALU_VLD,
    output logic        RES_VLD,
    input  logic        RES_ACK,
    output logic [31:0] RES_LO,
    output logic [31:0] RES_HI,
    output logic        RES_WIDE,
    output logic [3:0]  RES_TAG,
    output logic        RES_ERR
);

    drv_state_e  state_q;
    drv_state_e  state_d;
    alu_cmd_t    cmd_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        err_q;
    logic        tmo;
    logic        expired;
    logic        accept;
    logic        wd_clr;
    logic        wd_en;

    assign accept = (state_q == ST_IDLE) && REQ_VLD;
    assign wd_clr = (state_d != state_q);
    assign wd_en  = state_q inside {ST_ISSUE, ST_WAIT_LO, ST_WAIT_HI};

    alu_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (wd_clr),
        .enable (wd_en),
        .expired(expired)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The phase event is tested first so it wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        tmo     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (REQ_VLD) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (ALU_RDY) begin
                    state_d = ST_WAIT_LO;
                end else if (expired) begin
                    state_d = ST_HOLD;
                    tmo     = 1'b1;
                end
            end
            ST_WAIT_LO: begin
                if (ALU_VLD) begin
                    state_d = cmd_q.wide ? ST_WAIT_HI : ST_HOLD;
                end else if (expired) begin
                    state_d = ST_HOLD;
                    tmo     = 1'b1;
                end
            end
            ST_WAIT_HI: begin
                if (ALU_VLD) begin
                    state_d = ST_HOLD;
                end else if (expired) begin
                    state_d = ST_HOLD;
                    tmo     = 1'b1;
                end
            end
            ST_HOLD: begin
                if (RES_ACK) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        REQ_RDY = (state_q == ST_IDLE) || RST;
        ALU_ACT = (state_q == ST_ISSUE) && ALU_RDY && !RST;
        RES_VLD = (state_q == ST_HOLD) && !RST;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cmd_q <= '0;
            lo_q  <= '0;
            hi_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q <= '{op:   REQ_OP,
                           movi: REQ_MOVI,
                           a:    REQ_A,
                           b:    REQ_B,
                           mem:  REQ_MEM,
                           imm:  REQ_IMM,
                           tag:  REQ_TAG,
                           wide: is_wide(REQ_OP)};
                lo_q  <= '0;
                hi_q  <= '0;
                err_q <= 1'b0;
            end
            if (tmo) begin
                lo_q  <= '0;
                hi_q  <= '0;
                err_q <= 1'b1;
            end
            if ((state_q == ST_WAIT_LO) && ALU_VLD) lo_q <= ALU_DATA;
            if ((state_q == ST_WAIT_HI) && ALU_VLD) hi_q <= ALU_DATA;
        end
    end

    assign ALU_OP    = cmd_q.op;
    assign ALU_MOVI  = cmd_q.movi;
    assign ALU_REG_A = cmd_q.a;
    assign ALU_REG_B = cmd_q.b;
    assign ALU_MEM   = cmd_q.mem;
    assign ALU_IMM   = cmd_q.imm;
    assign RES_LO    = lo_q;
    assign RES_HI    = hi_q;
    assign RES_WIDE  = cmd_q.wide;
    assign RES_TAG   = cmd_q.tag;
    assign RES_ERR   = err_q && !RST;

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 Parameter TIMEOUT, default 8: maximum cycles waited per ALU handshake phase before aborting.
REQ-002 Ports (name, direction, width, meaning):
- CLK, in, 1: single clock, all logic on rising edge.
- RST, in, 1: synchronous, active-high reset.
- REQ_VLD, in, 1: upstream command valid.
- REQ_RDY, out, 1: driver can accept a command.
- REQ_OP, in, 4: ALU opcode.
- REQ_MOVI, in, 2: operand-B source select.
- REQ_A, REQ_B, REQ_MEM, REQ_IMM, in, 32 each: operands.
- REQ_TAG, in, 4: command tag.
- ALU_ACT, out, 1: start request to the ALU.
- ALU_OP, out, 4: registered command field to the ALU.
- ALU_MOVI, out, 2: registered command field to the ALU.
- ALU_REG_A, ALU_REG_B, ALU_MEM, ALU_IMM, out, 32 each: registered command fields to the ALU.
- ALU_DATA, in, 32: ALU result beat.
- ALU_RDY, in, 1: ALU idle.
- ALU_VLD, in, 1: ALU result beat valid.
- RES_VLD, out, 1: result available.
- RES_ACK, in, 1: consumer takes result.
- RES_LO, out, 32: low result word.
- RES_HI, out, 32: high result word.
- RES_WIDE, out, 1: RES_HI is meaningful (multiply).
- RES_TAG, out, 4: tag of the command.
- RES_ERR, out, 1: command aborted by timeout.

Function
REQ-003 REQ_RDY SHALL be 1 only in state IDLE; a command is accepted on a rising edge where REQ_VLD and REQ_RDY are both 1.
REQ-004 On acceptance, all REQ_* fields SHALL be latched and driven on the ALU_* outputs, held stable until the driver returns to IDLE.
REQ-005 The multiply opcode is 4'b0010; an accepted multiply SHALL set the wide flag, all other opcodes clear it.
REQ-006 States SHALL be IDLE, ISSUE, WAIT_LO, WAIT_HI, HOLD.
- IDLE -> ISSUE on acceptance.
- ISSUE -> WAIT_LO on an edge where ALU_ACT and ALU_RDY are both 1.
- WAIT_LO -> WAIT_HI on ALU_VLD if wide, else -> HOLD.
- WAIT_HI -> HOLD on ALU_VLD.
- HOLD -> IDLE on RES_ACK.
REQ-007 ALU_ACT SHALL equal ALU_RDY in ISSUE and be 0 in every other state, so ACT is asserted for exactly one accepted cycle.
REQ-008 In WAIT_LO, ALU_VLD SHALL capture ALU_DATA into RES_LO; in WAIT_HI, ALU_VLD SHALL capture ALU_DATA into RES_HI.
REQ-009 RES_HI SHALL be 0 for non-wide commands.
REQ-010 RES_VLD SHALL be 1 exactly in HOLD, with RES_LO, RES_HI, RES_WIDE, RES_TAG and RES_ERR stable there; RES_ACK outside HOLD SHALL be ignored.
REQ-011 Latency from the acceptance edge (cycle 0): ACT in cycle 1, first VLD beat in cycle 2, and RES_VLD in cycle 3 (non-wide) or cycle 4 (wide), assuming a ready ALU.
REQ-012 A wait counter SHALL clear on entry to ISSUE, WAIT_LO and WAIT_HI, and increment each cycle in those states.
- If it reaches TIMEOUT without the exiting event, go to HOLD.
- Set RES_ERR=1 and force RES_LO=RES_HI=0.
- Keep RES_TAG.
REQ-013 The event SHALL win when it coincides with the timeout cycle.
REQ-014 ALU_VLD received in IDLE, ISSUE or HOLD SHALL be ignored and SHALL NOT alter any result field.
REQ-015 A command SHALL NOT be accepted in the HOLD cycle that sees RES_ACK; the earliest next acceptance is the following cycle in IDLE.

Reset
REQ-016 When RST is 1 at a rising edge, the state SHALL become IDLE, the counter 0, and all result and ALU_* registers 0, regardless of the current phase.
REQ-017 During and after reset, REQ_RDY=1, ALU_ACT=0, RES_VLD=0 and RES_ERR=0.
REQ-018 A command interrupted by reset SHALL be dropped without any result.

Structure
REQ-019 A shared package alu_pkg SHALL hold:
- the opcode enum, including OP_MUL=4'b0010;
- the MOVI source codes (00 REG_B, 01 MEM, 10 IMM);
- the driver state typedef.
REQ-020 The wait counter SHALL be a sub-module alu_wdog (inputs clear, enable; output expired; parameter TIMEOUT); everything else lives in alu_driver.

Verification
REQ-021 ADD, A=5, B=7, MOVI=00, tag 3, ALU model returns 12 one cycle after ACT.
- Expect RES_VLD in cycle 3 with RES_LO=12, RES_HI=0, WIDE=0, TAG=3, ERR=0.
REQ-022 MUL, A=0x10000, IMM=0x10000, MOVI=10, model returns beats 0 then 1.
- Expect RES_VLD in cycle 4 with RES_LO=0, RES_HI=1, WIDE=1.
REQ-023 ALU_RDY held 0 for 3 cycles after acceptance.
- Expect ALU_ACT=0 during those cycles, then exactly one ACT cycle, and the correct result.
REQ-024 Model never asserts VLD (TIMEOUT=8).
- Expect HOLD after 8 WAIT_LO cycles with RES_ERR=1, RES_LO=0, tag preserved.
- Expect IDLE after RES_ACK.
REQ-025 RST pulsed for one cycle during WAIT_HI of a multiply.
- Expect IDLE, REQ_RDY=1, RES_VLD=0 next cycle, and no result produced.
REQ-026 RES_ACK held 0 for 5 cycles in HOLD, with REQ_VLD=1 and stray ALU_VLD pulses.
- Expect outputs stable and REQ_RDY=0 throughout.
- Expect acceptance only after ACK plus one cycle.
